ext_bus_arb: RTL and testbench

Arbiter for the shared tri-state external data bus. Grants the bus to one of NREQ requesters (CPU, OAM DMA, …) by fixed priority with optional lock and anti-starvation preemption. Inserts a driver-free turnaround between owners so no two drivers overlap. Signals the bus keeper to hold the last value whenever nobody drives.

---
 rtl/ext_bus_arb.sv | 146 ++++++++++++++
 tb/tb_ext_bus_arb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_arb.sv
// ext_bus_arb: fixed-priority arbiter for the shared tri-state external bus.
// Inserts a driver-free turnaround between owners, supports per-requester
// lock with optional anti-starvation preemption, and drives the keeper enable.
module ext_bus_arb #(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned TURN     = 1,
  parameter int unsigned MAX_HOLD = 0
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NREQ-1:0]                          req,
  input  logic [NREQ-1:0]                          lock,
  input  logic [NREQ-1:0]                          wr,
  output logic [NREQ-1:0]                          grant,
  output logic [NREQ-1:0]                          drv_en,
  output logic                                     keep_en,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] owner,
  output logic                                     busy
);

  localparam int unsigned OW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW       = 4;
  localparam int unsigned HW       = 16;
  localparam logic [TW-1:0] TURN_INIT = TW'(TURN - 1);
  localparam bit            HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HW-1:0] HOLD_LIM  = HOLD_EN ? HW'(MAX_HOLD - 1) : '0;
  localparam logic [HW-1:0] HOLD_SAT  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [OW-1:0]   owner_nxt;
  logic            busy_nxt;
  logic [TW-1:0]   tcnt, tcnt_nxt;
  logic [HW-1:0]   hcnt, hcnt_nxt;

  logic            any_req;
  logic [OW-1:0]   win;
  logic [NREQ-1:0] win_oh;
  logic            hi_pend;
  logic            own_req;
  logic            own_lock;

  // Winner is the highest-index active request; also flag any request above the owner
  always_comb begin
    any_req  = |req;
    win      = '0;
    hi_pend  = 1'b0;
    own_req  = 1'b0;
    own_lock = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (req[i]) begin
        win = OW'(i);
        if (i > int'(owner)) hi_pend = 1'b1;
      end
      if (OW'(i) == owner) begin
        own_req  = req[i];
        own_lock = lock[i];
      end
    end
    win_oh = NREQ'(1) << win;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      grant <= '0;
      owner <= '0;
      busy  <= 1'b0;
      tcnt  <= '0;
      hcnt  <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      owner <= owner_nxt;
      busy  <= busy_nxt;
      tcnt  <= tcnt_nxt;
      hcnt  <= hcnt_nxt;
    end
  end

  // Next-state: grant, release/preempt into turnaround, re-arbitrate after it
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    owner_nxt = owner;
    tcnt_nxt  = tcnt;
    hcnt_nxt  = hcnt;
    unique case (state)
      S_IDLE: begin
        grant_nxt = '0;
        if (any_req) begin
          state_nxt = S_OWN;
          grant_nxt = win_oh;
          owner_nxt = win;
          hcnt_nxt  = '0;
        end
      end
      S_OWN: begin
        if (!own_req
            || (hi_pend && !own_lock)
            || (hi_pend && HOLD_EN && (hcnt == HOLD_LIM))) begin
          state_nxt = S_TURN;
          grant_nxt = '0;
          tcnt_nxt  = TURN_INIT;
          hcnt_nxt  = '0;
        end else if (hi_pend) begin
          hcnt_nxt = (hcnt == HOLD_SAT) ? hcnt : hcnt + HW'(1);
        end else begin
          hcnt_nxt = '0;
        end
      end
      S_TURN: begin
        grant_nxt = '0;
        if (tcnt == '0) begin
          if (any_req) begin
            state_nxt = S_OWN;
            grant_nxt = win_oh;
            owner_nxt = win;
            hcnt_nxt  = '0;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          tcnt_nxt = tcnt - TW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        grant_nxt = '0;
      end
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  // Tri-state enables follow wr in the same cycle; keeper holds when undriven
  assign drv_en  = grant & wr;
  assign keep_en = ~|drv_en;

endmodule

// File: tb/tb_ext_bus_arb.sv
// Testbench for ext_bus_arb: table-driven vectors on a TURN=1/MAX_HOLD=4
// instance, hand sequences on a TURN=3/MAX_HOLD=0 instance, random invariants.
module tb_ext_bus_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req, lock, wr;

  logic [2:0] grant_a, drv_a, grant_b, drv_b;
  logic       keep_a, keep_b, busy_a, busy_b;
  logic [1:0] owner_a, owner_b;

  int checks = 0;
  int errors = 0;

  ext_bus_arb #(.NREQ(3), .TURN(1), .MAX_HOLD(4)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .wr(wr),
    .grant(grant_a), .drv_en(drv_a), .keep_en(keep_a), .owner(owner_a), .busy(busy_a)
  );

  ext_bus_arb #(.NREQ(3), .TURN(3), .MAX_HOLD(0)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .wr(wr),
    .grant(grant_b), .drv_en(drv_b), .keep_en(keep_b), .owner(owner_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;
    logic [2:0] lock;
    logic [2:0] wr;
    logic [2:0] g;
    logic [1:0] o;
    logic       b;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [2:0] r, logic [2:0] l, logic [2:0] w,
                              logic [2:0] g, logic [1:0] o, logic b);
    vec_t v;
    v.req = r; v.lock = l; v.wr = w; v.g = g; v.o = o; v.b = b;
    return v;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare one instance's outputs; drv/keep expectations come from grant and wr
  task automatic chk_out(string tag, logic [2:0] g_act, logic [2:0] d_act, logic k_act,
                         logic [1:0] o_act, logic b_act,
                         logic [2:0] g, logic [1:0] o, logic b);
    logic [2:0] d;
    d = g & wr;
    chk({tag, " grant"},   8'(g_act), 8'(g));
    chk({tag, " drv_en"},  8'(d_act), 8'(d));
    chk({tag, " keep_en"}, 8'(k_act), 8'(~|d));
    chk({tag, " owner"},   8'(o_act), 8'(o));
    chk({tag, " busy"},    8'(b_act), 8'(b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [2:0] r, logic [2:0] l, logic [2:0] w);
    req = r; lock = l; wr = w;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(3'b000, 3'b000, 3'b000);

    // grant/release, priority, lock with forced preempt, lock on non-owner, swap
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0));
    tbl.push_back(mk(3'b001, 3'b000, 3'b001, 3'b001, 2'd0, 1'b1));
    tbl.push_back(mk(3'b001, 3'b000, 3'b000, 3'b001, 2'd0, 1'b1));
    tbl.push_back(mk(3'b001, 3'b000, 3'b001, 3'b001, 2'd0, 1'b1));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 2'd0, 1'b1));
    tbl.push_back(mk(3'b010, 3'b000, 3'b000, 3'b010, 2'd1, 1'b1));
    tbl.push_back(mk(3'b010, 3'b000, 3'b010, 3'b010, 2'd1, 1'b1));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 2'd1, 1'b1));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 2'd1, 1'b0));
    tbl.push_back(mk(3'b011, 3'b000, 3'b000, 3'b010, 2'd1, 1'b1));
    tbl.push_back(mk(3'b111, 3'b000, 3'b010, 3'b000, 2'd1, 1'b1));
    tbl.push_back(mk(3'b111, 3'b000, 3'b100, 3'b100, 2'd2, 1'b1));
    tbl.push_back(mk(3'b011, 3'b000, 3'b000, 3'b000, 2'd2, 1'b1));
    tbl.push_back(mk(3'b011, 3'b000, 3'b000, 3'b010, 2'd1, 1'b1));
    tbl.push_back(mk(3'b011, 3'b000, 3'b000, 3'b010, 2'd1, 1'b1));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 2'd1, 1'b1));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 2'd1, 1'b0));
    tbl.push_back(mk(3'b001, 3'b001, 3'b001, 3'b001, 2'd0, 1'b1));
    tbl.push_back(mk(3'b101, 3'b001, 3'b001, 3'b001, 2'd0, 1'b1));
    tbl.push_back(mk(3'b101, 3'b001, 3'b001, 3'b001, 2'd0, 1'b1));
    tbl.push_back(mk(3'b101, 3'b001, 3'b001, 3'b001, 2'd0, 1'b1));
    tbl.push_back(mk(3'b101, 3'b001, 3'b001, 3'b000, 2'd0, 1'b1));
    tbl.push_back(mk(3'b101, 3'b001, 3'b000, 3'b100, 2'd2, 1'b1));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 2'd2, 1'b1));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 2'd2, 1'b0));
    tbl.push_back(mk(3'b010, 3'b100, 3'b000, 3'b010, 2'd1, 1'b1));
    tbl.push_back(mk(3'b110, 3'b001, 3'b000, 3'b000, 2'd1, 1'b1));
    tbl.push_back(mk(3'b110, 3'b001, 3'b000, 3'b100, 2'd2, 1'b1));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 2'd2, 1'b1));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 2'd2, 1'b0));
    tbl.push_back(mk(3'b001, 3'b000, 3'b000, 3'b001, 2'd0, 1'b1));
    tbl.push_back(mk(3'b100, 3'b000, 3'b000, 3'b000, 2'd0, 1'b1));
    tbl.push_back(mk(3'b100, 3'b000, 3'b000, 3'b100, 2'd2, 1'b1));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 2'd2, 1'b1));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 2'd2, 1'b0));

    #12;
    chk_out("reset a", grant_a, drv_a, keep_a, owner_a, busy_a, 3'b000, 2'd0, 1'b0);
    chk_out("reset b", grant_b, drv_b, keep_b, owner_b, busy_b, 3'b000, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].lock, tbl[i].wr);
      tick();
      chk_out($sformatf("row%0d", i), grant_a, drv_a, keep_a, owner_a, busy_a,
              tbl[i].g, tbl[i].o, tbl[i].b);
    end

    // Asynchronous reset in the middle of an ownership with wr asserted
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b100, 3'b000, 3'b100);
    tick();
    chk_out("own a", grant_a, drv_a, keep_a, owner_a, busy_a, 3'b100, 2'd2, 1'b1);
    chk_out("own b", grant_b, drv_b, keep_b, owner_b, busy_b, 3'b100, 2'd2, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async rst a", grant_a, drv_a, keep_a, owner_a, busy_a, 3'b000, 2'd0, 1'b0);
    chk_out("async rst b", grant_b, drv_b, keep_b, owner_b, busy_b, 3'b000, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b001, 3'b000, 3'b000);
    tick();
    chk_out("post rst a", grant_a, drv_a, keep_a, owner_a, busy_a, 3'b001, 2'd0, 1'b1);
    chk_out("post rst b", grant_b, drv_b, keep_b, owner_b, busy_b, 3'b001, 2'd0, 1'b1);

    // TURN=3 handover 0 -> 1: three undriven cycles, then grant
    drive(3'b010, 3'b000, 3'b010);
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk_out($sformatf("turn3 c%0d", c), grant_b, drv_b, keep_b, owner_b, busy_b,
              3'b000, 2'd0, 1'b1);
    end
    tick();
    chk_out("turn3 grant", grant_b, drv_b, keep_b, owner_b, busy_b, 3'b010, 2'd1, 1'b1);

    // Request appearing then dropping during turnaround is never granted
    drive(3'b001, 3'b000, 3'b000);
    tick();
    chk_out("drop t1", grant_b, drv_b, keep_b, owner_b, busy_b, 3'b000, 2'd1, 1'b1);
    drive(3'b000, 3'b000, 3'b000);
    tick();
    tick();
    chk_out("drop t3", grant_b, drv_b, keep_b, owner_b, busy_b, 3'b000, 2'd1, 1'b1);
    tick();
    chk_out("drop idle", grant_b, drv_b, keep_b, owner_b, busy_b, 3'b000, 2'd1, 1'b0);

    // MAX_HOLD=0: locked owner keeps the bus while a higher request waits
    drive(3'b001, 3'b001, 3'b001);
    tick();
    chk_out("lock grant", grant_b, drv_b, keep_b, owner_b, busy_b, 3'b001, 2'd0, 1'b1);
    drive(3'b101, 3'b001, 3'b001);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk_out($sformatf("lock hold%0d", c), grant_b, drv_b, keep_b, owner_b, busy_b,
              3'b001, 2'd0, 1'b1);
    end
    drive(3'b100, 3'b000, 3'b000);
    tick();
    chk_out("lock rel", grant_b, drv_b, keep_b, owner_b, busy_b, 3'b000, 2'd0, 1'b1);
    tick();
    tick();
    tick();
    chk_out("lock next", grant_b, drv_b, keep_b, owner_b, busy_b, 3'b100, 2'd2, 1'b1);

    // Random stimulus: ownership and drive enables stay one-hot-or-zero
    for (int c = 0; c < 300; c++) begin
      drive(3'($urandom()), 3'($urandom()), 3'($urandom()));
      tick();
      chk("onehot grant a", 8'($onehot0(grant_a)), 8'd1);
      chk("onehot drv a",   8'($onehot0(drv_a)),   8'd1);
      chk("onehot grant b", 8'($onehot0(grant_b)), 8'd1);
      chk("onehot drv b",   8'($onehot0(drv_b)),   8'd1);
      chk("keep a", 8'(keep_a), 8'(~|(grant_a & wr)));
      chk("keep b", 8'(keep_b), 8'(~|(grant_b & wr)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
